uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one byte-wide UART transmitter among NUM_REQ requesters using a
// round-robin grant. A grant latches the requester's byte, strobes the
// transmitter once, and then waits for the transmitter's completion pulse
// or for a timeout. The requester is told the outcome with a single-cycle
// ack (sent) or err (abandoned).
//
// Ports
//   clock           rising-edge clock for all state
//   reset           asynchronous active-low reset
//   req             per-requester level request, held until ack/err
//   req_data        packed bytes, requester i owns [8i+7:8i]
//   ack             one-cycle pulse: byte of requester i transmitted
//   err             one-cycle pulse: grant to requester i timed out
//   tx_data_valid   one-cycle start strobe to the transmitter
//   tx_data_in      byte latched from the granted requester
//   tx_transmitting transmitter status (observed only)
//   tx_done         transmitter completion pulse
//   busy            high whenever the FSM is not idle
//   grant_id        index of the current or most recent grant
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         err,
    output logic                       tx_data_valid,
    output logic [7:0]                 tx_data_in,
    input  logic                       tx_transmitting,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    // One extra bit so pointer + offset can be compared against NUM_REQ
    // before wrapping (NUM_REQ need not be a power of two).
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]     grant_id_reg, grant_id_next;
    logic [7:0]           tx_data_reg, tx_data_next;
    logic                 tx_valid_reg, tx_valid_next;
    logic [NUM_REQ-1:0]   ack_reg, ack_next;
    logic [NUM_REQ-1:0]   err_reg, err_next;
    logic                 busy_reg, busy_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;

    // Transmitter status is informational; the arbiter trusts tx_done only.
    logic tx_transmitting_unused;
    assign tx_transmitting_unused = tx_transmitting;

    // Unpack the per-requester bytes.
    logic [7:0] req_byte [NUM_REQ];
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_byte
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    // Round-robin search: first asserted request at or above rr_ptr,
    // wrapping from NUM_REQ-1 back to 0.
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W:0]   cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!sel_found && req[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer value after finishing with the current grant: the requester
    // just served becomes lowest priority.
    logic [IDX_W:0]   grant_inc;
    logic [IDX_W-1:0] rr_after_grant;

    always_comb begin
        grant_inc = {1'b0, grant_id_reg} + (IDX_W + 1)'(1);
        if (grant_inc >= NUM_REQ_W) begin
            grant_inc = '0;
        end
        rr_after_grant = grant_inc[IDX_W-1:0];
    end

    logic [NUM_REQ-1:0] grant_onehot;
    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_reg;

    // Next-state and registered-output logic.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        tx_data_next  = tx_data_reg;
        cnt_next      = cnt_reg;
        tx_valid_next = 1'b0;
        ack_next      = '0;
        err_next      = '0;

        case (state_reg)
            IDLE: begin
                // tx_done arriving here is stale and deliberately ignored.
                if (sel_found) begin
                    grant_id_next = sel_idx;
                    tx_data_next  = req_byte[sel_idx];
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                // The strobe register goes high on leaving ISSUE, so the
                // transmitter sees exactly one valid cycle per grant.
                tx_valid_next = 1'b1;
                cnt_next      = '0;
                state_next    = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Completion takes priority over a timeout on the same edge.
                if (tx_done) begin
                    ack_next    = grant_onehot;
                    rr_ptr_next = rr_after_grant;
                    state_next  = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next    = grant_onehot;
                    rr_ptr_next = rr_after_grant;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
            ack_reg      <= '0;
            err_reg      <= '0;
            busy_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            busy_reg     <= busy_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign ack           = ack_reg;
    assign err           = err_reg;
    assign tx_data_valid = tx_valid_reg;
    assign tx_data_in    = tx_data_reg;
    assign busy          = busy_reg;
    assign grant_id      = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        tx_data_valid;
    logic [7:0]  tx_data_in;
    logic        tx_transmitting = 1'b0;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [1:0]  grant_id;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .req_data        (req_data),
        .ack             (ack),
        .err             (err),
        .tx_data_valid   (tx_data_valid),
        .tx_data_in      (tx_data_in),
        .tx_transmitting (tx_transmitting),
        .tx_done         (tx_done),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    always #5 clock = ~clock;

    // Status input toggles randomly; it must never influence the arbiter.
    always @(negedge clock) begin
        tx_transmitting = 1'($urandom_range(0, 1));
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          dly;     // tx_done delay after strobe; -1 = never
        logic [1:0]  gid;
        logic [7:0]  bval;
        logic        is_err;
        logic        mutate;  // drop req and scramble data after grant
    } vec_t;

    typedef struct {
        logic [1:0] gid;
        logic [7:0] bval;
        logic [3:0] onehot;
        logic       is_err;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        int   n;
        bit   seen;
        int   exp_lat;

        req      = v.req;
        req_data = v.data;
        e.gid    = v.gid;
        e.bval   = v.bval;
        e.onehot = 4'b0001 << v.gid;
        e.is_err = v.is_err;
        sb_q.push_back(e);

        n = 0;
        while (tx_data_valid !== 1'b1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        if (tx_data_valid !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL strobe_timeout[%0d]: tx_data_valid=%b required 1 within 8 cycles", idx, tx_data_valid);
            got = sb_q.pop_front();
            return;
        end
        check($sformatf("strobe_latency[%0d]", idx), 32'(n), 32'd2);

        got = sb_q.pop_front();
        check($sformatf("grant_id[%0d]", idx), 32'(grant_id), 32'(got.gid));
        check($sformatf("tx_data_in[%0d]", idx), 32'(tx_data_in), 32'(got.bval));
        check($sformatf("busy_wait[%0d]", idx), 32'(busy), 32'd1);

        if (v.mutate) begin
            req      = 4'b0000;
            req_data = ~v.data;
        end

        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clock);
            n++;
            tx_done = 1'b0;
            if (n == 1) begin
                check($sformatf("strobe_len[%0d]", idx), 32'(tx_data_valid), 32'd0);
            end
            if (ack !== 4'b0000 || err !== 4'b0000) begin
                seen = 1'b1;
            end else if (v.dly >= 0 && n == v.dly + 1) begin
                tx_done = 1'b1;
            end
        end

        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL completion_timeout[%0d]: ack=%b err=%b required a pulse within 40 cycles", idx, ack, err);
            return;
        end

        exp_lat = got.is_err ? 16 : v.dly + 2;
        check($sformatf("ack[%0d]", idx), 32'(ack), got.is_err ? 32'd0 : 32'(got.onehot));
        check($sformatf("err[%0d]", idx), 32'(err), got.is_err ? 32'(got.onehot) : 32'd0);
        check($sformatf("done_latency[%0d]", idx), 32'(n), 32'(exp_lat));
        check($sformatf("busy_idle[%0d]", idx), 32'(busy), 32'd0);
        check($sformatf("data_hold[%0d]", idx), 32'(tx_data_in), 32'(got.bval));
        $display("[TB] txn %0d: req=%b grant=%0d byte=%02h %s after %0d cycles",
                 idx, v.req, grant_id, tx_data_in, (err != 4'b0000) ? "err" : "ack", n);
    endtask

    initial begin
        int n;

        //              req      data          dly gid   byte   err   mutate
        vecs[0]  = '{4'b1111, 32'hA3A2A1A0,  2, 2'd0, 8'hA0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 32'hA3A2A1A0,  0, 2'd1, 8'hA1, 1'b0, 1'b0};
        vecs[2]  = '{4'b1111, 32'hA3A2A1A0,  5, 2'd2, 8'hA2, 1'b0, 1'b0};
        vecs[3]  = '{4'b1111, 32'hA3A2A1A0,  1, 2'd3, 8'hA3, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 32'hA3A2A1A0,  3, 2'd0, 8'hA0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0100, 32'h5A3F7788,  4, 2'd2, 8'h3F, 1'b0, 1'b0};
        vecs[6]  = '{4'b1000, 32'hC4000000,  0, 2'd3, 8'hC4, 1'b0, 1'b0};
        vecs[7]  = '{4'b1001, 32'hD3000011,  1, 2'd0, 8'h11, 1'b0, 1'b0};
        vecs[8]  = '{4'b1001, 32'hD3000011,  2, 2'd3, 8'hD3, 1'b0, 1'b0};
        vecs[9]  = '{4'b0001, 32'h00000077, -1, 2'd0, 8'h77, 1'b1, 1'b0};
        vecs[10] = '{4'b0010, 32'h00004400, 14, 2'd1, 8'h44, 1'b0, 1'b0};
        vecs[11] = '{4'b0011, 32'h00005566,  2, 2'd0, 8'h66, 1'b0, 1'b1};
        vecs[12] = '{4'b0011, 32'h00009988,  1, 2'd0, 8'h88, 1'b0, 1'b0};
        vecs[13] = '{4'b0010, 32'h00007700,  0, 2'd1, 8'h77, 1'b0, 1'b0};

        // Reset state.
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(tx_data_valid), 32'd0);
        check("rst_data", 32'(tx_data_in), 32'h00);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            apply_vec(i, vecs[i]);
        end
        req = 4'b0000;
        @(negedge clock);
        check("ack_one_cycle", 32'(ack), 32'd0);

        // Stale tx_done while idle with no requests.
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stale_busy[%0d]", i), 32'(busy), 32'd0);
            check($sformatf("stale_valid[%0d]", i), 32'(tx_data_valid), 32'd0);
            check($sformatf("stale_ack[%0d]", i), 32'(ack | err), 32'd0);
            @(negedge clock);
        end

        // Reset in the middle of a transfer.
        req      = 4'b1000;
        req_data = 32'hEE000000;
        n = 0;
        while (tx_data_valid !== 1'b1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        check("abort_strobe", 32'(tx_data_valid), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(tx_data_in), 32'h00);
        check("abort_grant", 32'(grant_id), 32'd0);
        req = 4'b0000;
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        @(negedge clock);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_post_ack", 32'(ack | err), 32'd0);

        // Arbitration restarts from requester 0, then a normal single request.
        apply_vec(12, vecs[12]);
        apply_vec(13, vecs[13]);
        req = 4'b0000;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
